// File: rtl/jk_excitation_driver.sv
// Drives a bank of external JK flip-flops toward a target word for one clock,
// then checks the bank's Q and keeps a saturating count of failed updates.
module jk_excitation_driver #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tgt_valid,
  output logic                 tgt_ready,
  input  logic [WIDTH-1:0]     tgt_data,
  input  logic [WIDTH-1:0]     q_in,
  output logic [WIDTH-1:0]     j_out,
  output logic [WIDTH-1:0]     k_out,
  output logic                 busy,
  output logic                 done,
  output logic                 mismatch,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 clr_err
);

  typedef enum logic [1:0] {StIdle, StDrive, StCheck} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] tgt_q;
  logic             fail_now;

  assign fail_now  = (state_q == StCheck) && (q_in != tgt_q);
  // Gated with rst_n so the block never advertises ready while held in reset.
  assign tgt_ready = rst_n && (state_q == StIdle);
  assign busy      = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      tgt_q    <= '0;
      j_out    <= '0;
      k_out    <= '0;
      done     <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      done     <= 1'b0;
      mismatch <= 1'b0;
      j_out    <= '0;
      k_out    <= '0;
      unique case (state_q)
        StIdle: begin
          if (tgt_valid) begin
            tgt_q   <= tgt_data;
            // Set only bits rising, reset only bits falling; toggle never issued.
            j_out   <= tgt_data & ~q_in;
            k_out   <= ~tgt_data & q_in;
            state_q <= StDrive;
          end
        end
        StDrive: state_q <= StCheck;
        StCheck: begin
          done     <= 1'b1;
          mismatch <= fail_now;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Clear takes priority but a simultaneous mismatch still counts once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr_err) begin
      err_count <= ERR_CNT_W'(fail_now);
    end else if (fail_now && (err_count != '1)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule
